// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges ID load-use and EX multi-cycle stalls, arbitrates redirects.
// Outputs are combinational from state and inputs (same-cycle effect); an N-cycle EX op holds the front end N-1 cycles.
module pipeline_controller #(
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_stall_request,
  input  logic                   ex_multicycle_start,
  input  logic [COUNT_WIDTH-1:0] ex_multicycle_cycles,
  input  logic                   flush_request,
  input  logic [31:0]            flush_target,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [31:0]            new_program_counter,
  output logic                   ex_multicycle_done,
  output logic                   busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    stall               = STALL_NONE;
    flush               = 1'b0;
    new_program_counter = 32'h0;
    ex_multicycle_done  = 1'b0;
    busy                = 1'b0;

    if (!reset) begin
      busy = (state_q == MULTI);
      if (flush_request) begin
        // A redirect kills any in-flight multi-cycle op outright.
        flush               = 1'b1;
        new_program_counter = flush_target;
        state_d             = IDLE;
        cnt_d               = '0;
      end else if (state_q == MULTI) begin
        if (cnt_q > COUNT_WIDTH'(1)) begin
          stall = STALL_EX;
          cnt_d = cnt_q - COUNT_WIDTH'(1);
        end else begin
          ex_multicycle_done = 1'b1;
          state_d            = IDLE;
          cnt_d              = '0;
        end
      end else if (ex_multicycle_start) begin
        if (ex_multicycle_cycles <= COUNT_WIDTH'(1)) begin
          ex_multicycle_done = 1'b1;
        end else begin
          // The start cycle counts as the first EX cycle, so N-1 remain.
          stall   = STALL_EX;
          cnt_d   = ex_multicycle_cycles - COUNT_WIDTH'(1);
          state_d = MULTI;
        end
      end else if (id_stall_request) begin
        stall = STALL_ID;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: inputs change 1ns after the rising edge, outputs sampled on the falling edge.
module tb_pipeline_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_stall_request;
  logic        ex_multicycle_start;
  logic [5:0]  ex_multicycle_cycles;
  logic        flush_request;
  logic [31:0] flush_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_program_counter;
  logic        ex_multicycle_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  pipeline_controller #(.COUNT_WIDTH(6)) dut (
    .clock                (clock),
    .reset                (reset),
    .id_stall_request     (id_stall_request),
    .ex_multicycle_start  (ex_multicycle_start),
    .ex_multicycle_cycles (ex_multicycle_cycles),
    .flush_request        (flush_request),
    .flush_target         (flush_target),
    .stall                (stall),
    .flush                (flush),
    .new_program_counter  (new_program_counter),
    .ex_multicycle_done   (ex_multicycle_done),
    .busy                 (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                         input logic [31:0] e_npc, input logic e_done, input logic e_busy);
    check({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
    check({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
    check({tag, ".npc"},   new_program_counter, e_npc);
    check({tag, ".done"},  {31'h0, ex_multicycle_done}, {31'h0, e_done});
    check({tag, ".busy"},  {31'h0, busy}, {31'h0, e_busy});
  endtask

  task automatic drive(input logic rst, input logic ids, input logic st, input logic [5:0] n,
                       input logic fl, input logic [31:0] tgt);
    reset                = rst;
    id_stall_request     = ids;
    ex_multicycle_start  = st;
    ex_multicycle_cycles = n;
    flush_request        = fl;
    flush_target         = tgt;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int stall_cycles;
    bit seen_done;

    // Reset held 3 cycles with every request asserted.
    drive(1'b1, 1'b1, 1'b1, 6'd4, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk_out($sformatf("rst%0d", i), 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample();
    chk_out("post_rst", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    advance();

    // Load-use stall for two cycles.
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("ids0", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    sample(); chk_out("ids1", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("ids_end", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();

    // N=4: start plus two MULTI stall cycles, then done; ID/start ignored in MULTI.
    drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 32'h0);
    sample(); chk_out("n4_c1", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b1, 1'b1, 6'd2, 1'b0, 32'h0);
    sample(); chk_out("n4_c2", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n4_c3", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1); advance();
    sample(); chk_out("n4_c4", 6'h00, 1'b0, 32'h0, 1'b1, 1'b1); advance();
    sample(); chk_out("n4_idle", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();

    // N=1 with load-use: single-cycle op wins, no stall.
    drive(1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 32'h0);
    sample(); chk_out("n1", 6'h00, 1'b0, 32'h0, 1'b1, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n0", 6'h00, 1'b0, 32'h0, 1'b1, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n1_after", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();

    // N=5 aborted by a flush on the second MULTI cycle.
    drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 32'h0);
    sample(); chk_out("n5_c1", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n5_m1", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1); advance();
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 32'h0000_0100);
    sample(); chk_out("n5_flush", 6'h00, 1'b1, 32'h0000_0100, 1'b0, 1'b1); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0000_0100);
    sample(); chk_out("n5_after", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();

    // Flush outranks a start in IDLE.
    drive(1'b0, 1'b1, 1'b1, 6'd6, 1'b1, 32'h1234_5678);
    sample(); chk_out("fl_idle", 6'h00, 1'b1, 32'h1234_5678, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("fl_idle_after", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();

    // N=8 interrupted by reset after 3 cycles, then a fresh N=2.
    drive(1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 32'h0);
    sample(); chk_out("n8_c1", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n8_c2", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1); advance();
    sample(); chk_out("n8_c3", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1); advance();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n8_rst", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n8_idle", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 32'h0);
    sample(); chk_out("n2_c1", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    sample(); chk_out("n2_c2", 6'h00, 1'b0, 32'h0, 1'b1, 1'b1); advance();
    sample(); chk_out("n2_idle", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();

    // Maximum length N=63: exactly 62 held cycles, then done.
    drive(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 32'h0);
    stall_cycles = 0;
    seen_done    = 1'b0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      sample();
      if (stall == 6'b001111) stall_cycles++;
      if (ex_multicycle_done) seen_done = 1'b1;
      advance();
      drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    end
    check("n63_done_seen", {31'h0, seen_done}, 32'd1);
    check("n63_stall_cycles", stall_cycles, 32'd62);
    sample(); chk_out("n63_idle", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0); advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
